p_fifo_sync: RTL and testbench
==============================

# p_fifo_sync

Single-clock synchronous FIFO, 1024 × 8 by default. It buffers write-side data to a read side in the same clock domain, such as the oscilloscope sample capture path. It provides full, empty, almost-full and almost-empty flags. Read data comes from a registered memory read with one-cycle latency and no extra output register.

## Interface
- `WR_DEPTH_WIDTH`, default 10: log2 of depth; depth = 2^WR_DEPTH_WIDTH.
- `WR_DATA_WIDTH`, default 8: write word width.
- `RD_DEPTH_WIDTH`, default 10: must equal WR_DEPTH_WIDTH.
- `RD_DATA_WIDTH`, default 8: must equal WR_DATA_WIDTH.
- `ALMOST_FULL_NUM`, default 900: almost-full threshold, in words.
- `ALMOST_EMPTY_NUM`, default 500: almost-empty threshold, in words.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset; one clock; reset is synchronous and active-low.
- `wr_data`, input, WR_DATA_WIDTH: write word.
- `wr_en`, input, 1: write request.
- `wr_full`, output, 1: FIFO holds 2^WR_DEPTH_WIDTH words.
- `almost_full`, output, 1: count ≥ ALMOST_FULL_NUM.
- `rd_data`, output, RD_DATA_WIDTH: read word.
- `rd_en`, input, 1: read request.
- `rd_empty`, output, 1: FIFO holds 0 words.
- `almost_empty`, output, 1: count ≤ ALMOST_EMPTY_NUM.

## Operation
- Write and read pointers are (DEPTH_WIDTH+1) bits wide. The MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and the MSBs differ.
- Count = wr_ptr − rd_ptr, computed modulo 2^(DEPTH_WIDTH+1). It ranges 0…2^DEPTH_WIDTH.
- Accepted write: `wr_en && !wr_full`, using the flag value before the edge. The word is stored at wr_ptr[DEPTH_WIDTH-1:0] and wr_ptr increments.
- Accepted read: `rd_en && !rd_empty`. The memory word at rd_ptr is registered into rd_data and rd_ptr increments.
- A write while full is dropped; contents and pointers are unchanged.
- A read while empty is ignored; rd_data holds its previous value.
- Simultaneous write and read:
  - Each is judged independently against the pre-edge flags.
  - Both accepted: count is unchanged.
  - When full, only the read is accepted.
  - When empty, only the write is accepted; no write-through to rd_data.
- Pointer wrap is natural binary rollover; ordering is preserved across the wrap.
- Reset (rst=0 at a rising edge) clears both pointers.
  - Outputs after reset: wr_full=0, almost_full=0, rd_empty=1, almost_empty=1, rd_data=0.
  - Memory contents are not cleared.
- Reset asserted mid-operation discards all stored data; any request in that cycle is ignored.

## Timing
- All flags are registered and reflect the count after the current edge's accepted operations.
- A write at edge N makes rd_empty fall at edge N.
- The earliest read of that word is sampled at edge N+1, and its data is valid on rd_data after edge N+1.
- Read latency: rd_en sampled at edge N gives the word on rd_data after edge N, stable through edge N+1.
- wr_full rises on the edge where the 1024th word is accepted, and falls on the edge of the next accepted read.
- almost_full / almost_empty change on the edge where the count crosses the threshold.

## Configuration
- Macro `P_FIFO_WATER_LEVEL_EN`:
  - Defined: adds registered outputs `wr_water_level` and `rd_water_level`, each [DEPTH_WIDTH:0], both equal to the current count; reset value 0.
  - Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `p_fifo_pkg` holds the default width and depth constants and the threshold defaults.
- Sub-module `p_fifo_ram` is a simple dual-port RAM: one write port, one registered synchronous read port, no reset on the array.
- Pointer, count and flag logic live in the top module.

## Test plan
- Reset, then idle: rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
- Write 1025 consecutive words 0xFF, 0xFE, … (decrementing, wrapping mod 256):
  - almost_empty falls when count reaches 501.
  - almost_full rises when count reaches 900.
  - wr_full rises on the 1024th write.
  - The 1025th write is dropped.
- Then 1025 consecutive reads:
  - rd_data sequence is 0xFF, 0xFE, …, one cycle after each rd_en.
  - After 1024 reads, rd_empty=1.
  - The 1025th read is ignored and rd_data holds 0x00.
- Simultaneous wr_en and rd_en with count 10 for 20 cycles: count stays 10, data order is preserved, flags are unchanged.
- Full FIFO with wr_en=rd_en=1: the read is accepted, the write is dropped, and wr_full falls.
- Empty FIFO with wr_en=rd_en=1: the write is accepted, the read is ignored, rd_empty falls and rd_data is unchanged.
- Reset pulse with count 300: next cycle rd_empty=1 and count is 0; subsequent data starts fresh.

Source files
------------

// File: rtl/p_fifo_pkg.sv
// Shared defaults for the p_fifo family: geometry and watermark thresholds.
// Optional feature macro used by the top: P_FIFO_WATER_LEVEL_EN.
package p_fifo_pkg;

  localparam int DEF_DEPTH_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ALMOST_FULL  = 900;
  localparam int DEF_ALMOST_EMPTY = 500;

endpackage

// File: rtl/p_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset; only the read register clears.
module p_fifo_ram
  import p_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_DEPTH_WIDTH,
  parameter int DATA_W = DEF_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/p_fifo_sync.sv
// Single-clock FIFO with registered full/empty/almost flags and 1-cycle read latency.
// Define P_FIFO_WATER_LEVEL_EN to add registered wr_water_level/rd_water_level outputs.
module p_fifo_sync
  import p_fifo_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH   = DEF_DEPTH_WIDTH,
  parameter int WR_DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int RD_DEPTH_WIDTH   = DEF_DEPTH_WIDTH,
  parameter int RD_DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL,
  parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic                     almost_empty
`ifdef P_FIFO_WATER_LEVEL_EN
  ,
  output logic [WR_DEPTH_WIDTH:0]  wr_water_level,
  output logic [RD_DEPTH_WIDTH:0]  rd_water_level
`endif
);

  localparam int CW = WR_DEPTH_WIDTH + 1;
  localparam logic [WR_DEPTH_WIDTH:0] DEPTH_CNT = CW'(2 ** WR_DEPTH_WIDTH);
  localparam logic [WR_DEPTH_WIDTH:0] AF_TH     = CW'(ALMOST_FULL_NUM);
  localparam logic [WR_DEPTH_WIDTH:0] AE_TH     = CW'(ALMOST_EMPTY_NUM);

  logic [WR_DEPTH_WIDTH:0] wr_ptr, wr_ptr_nxt;
  logic [RD_DEPTH_WIDTH:0] rd_ptr, rd_ptr_nxt;
  logic [WR_DEPTH_WIDTH:0] count_nxt;
  logic                    wr_accept, rd_accept;

  // Acceptance is judged against the registered (pre-edge) flags.
  assign wr_accept = wr_en && !wr_full;
  assign rd_accept = rd_en && !rd_empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (wr_accept) wr_ptr_nxt = wr_ptr + CW'(1);
    if (rd_accept) rd_ptr_nxt = rd_ptr + CW'(1);
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Flags are registered from the post-edge count so they track accepted operations.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      wr_full      <= (count_nxt == DEPTH_CNT);
      almost_full  <= (count_nxt >= AF_TH);
      rd_empty     <= (count_nxt == '0);
      almost_empty <= (count_nxt <= AE_TH);
    end
  end

`ifdef P_FIFO_WATER_LEVEL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_water_level <= '0;
      rd_water_level <= '0;
    end else begin
      wr_water_level <= count_nxt;
      rd_water_level <= count_nxt;
    end
  end
`endif

  p_fifo_ram #(
    .ADDR_W (WR_DEPTH_WIDTH),
    .DATA_W (WR_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept && rst),
    .wr_addr (wr_ptr[WR_DEPTH_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept && rst),
    .rd_addr (rd_ptr[RD_DEPTH_WIDTH-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_p_fifo_sync.sv
// Directed bench for p_fifo_sync: vector table plus fill/drain, steady-state and reset sequences.
module tb_p_fifo_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       wr_full, almost_full, rd_empty, almost_empty;
  logic [7:0] rd_data;
`ifdef P_FIFO_WATER_LEVEL_EN
  logic [10:0] wr_wl, rd_wl;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic [7:0] exp_rd = 8'h00;

  always #5 clk = ~clk;

  p_fifo_sync dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .rd_data      (rd_data),
    .rd_en        (rd_en),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty)
`ifdef P_FIFO_WATER_LEVEL_EN
    ,
    .wr_water_level (wr_wl),
    .rd_water_level (rd_wl)
`endif
  );

  typedef struct {
    string      name;
    logic       we;
    logic       re;
    logic [7:0] wd;
    logic       full;
    logic       af;
    logic       empty;
    logic       ae;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, then update the scoreboard using pre-edge occupancy.
  task automatic apply(input logic we, input logic re, input logic [7:0] wd);
    int n;
    n = q.size();
    wr_en = we;
    rd_en = re;
    wr_data = wd;
    @(posedge clk);
    #1;
    if (re && n != 0) exp_rd = q.pop_front();
    if (we && n != 1024) q.push_back(wd);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    check({tag, "_full"},  {31'd0, wr_full},      {31'd0, n == 1024});
    check({tag, "_af"},    {31'd0, almost_full},  {31'd0, n >= 900});
    check({tag, "_empty"}, {31'd0, rd_empty},     {31'd0, n == 0});
    check({tag, "_ae"},    {31'd0, almost_empty}, {31'd0, n <= 500});
    check({tag, "_rd"},    {24'd0, rd_data},      {24'd0, exp_rd});
`ifdef P_FIFO_WATER_LEVEL_EN
    check({tag, "_wwl"},   {21'd0, wr_wl},        n);
    check({tag, "_rwl"},   {21'd0, rd_wl},        n);
`endif
  endtask

  // Reset cycle with requests asserted; they must be ignored.
  task automatic do_reset();
    rst = 1'b0;
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    q.delete();
    exp_rd = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_full"},  {31'd0, wr_full},      32'd0);
    check({tag, "_af"},    {31'd0, almost_full},  32'd0);
    check({tag, "_empty"}, {31'd0, rd_empty},     32'd1);
    check({tag, "_ae"},    {31'd0, almost_empty}, 32'd1);
    check({tag, "_rd"},    {24'd0, rd_data},      32'd0);
  endtask

  initial begin
    vecs[0] = '{"wr_first",      1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{"wr_rd_both",    1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1};
    vecs[2] = '{"rd_last",       1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2};
    vecs[3] = '{"rd_empty_ign",  1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2};
    vecs[4] = '{"wr_rd_empty",   1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB2};
    vecs[5] = '{"rd_c3",         1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3};
    vecs[6] = '{"idle_hold",     1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_reset_state("reset");
    apply(1'b0, 1'b0, 8'h00);
    check_reset_state("idle");

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].we, vecs[i].re, vecs[i].wd);
      check({vecs[i].name, "_full"},  {31'd0, wr_full},      {31'd0, vecs[i].full});
      check({vecs[i].name, "_af"},    {31'd0, almost_full},  {31'd0, vecs[i].af});
      check({vecs[i].name, "_empty"}, {31'd0, rd_empty},     {31'd0, vecs[i].empty});
      check({vecs[i].name, "_ae"},    {31'd0, almost_empty}, {31'd0, vecs[i].ae});
      check({vecs[i].name, "_rd"},    {24'd0, rd_data},      {24'd0, vecs[i].rd});
    end

    // Fill with 1025 decrementing words; the last is dropped.
    for (int i = 0; i < 1025; i++) begin
      apply(1'b1, 1'b0, 8'(255 - i));
      check_model("fill");
      if (i == 499) check("ae_at_500", {31'd0, almost_empty}, 32'd1);
      if (i == 500) check("ae_at_501", {31'd0, almost_empty}, 32'd0);
      if (i == 898) check("af_at_899", {31'd0, almost_full}, 32'd0);
      if (i == 899) check("af_at_900", {31'd0, almost_full}, 32'd1);
      if (i == 1022) check("full_at_1023", {31'd0, wr_full}, 32'd0);
      if (i == 1023) check("full_at_1024", {31'd0, wr_full}, 32'd1);
    end

    // Drain with 1025 reads; the last is ignored.
    for (int i = 0; i < 1025; i++) begin
      apply(1'b0, 1'b1, 8'h00);
      check_model("drain");
      if (i < 1024) check("drain_seq", {24'd0, rd_data}, {24'd0, 8'(255 - i)});
    end
    check("drain_last_hold", {24'd0, rd_data}, 32'h00);
    check("drain_empty", {31'd0, rd_empty}, 32'd1);

    // Steady state: count 10 with simultaneous read and write for 20 cycles.
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b1, 8'(10 + i));
      check_model("steady");
      check("steady_seq", {24'd0, rd_data}, i);
    end
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 8'h00);
      check("steady_tail", {24'd0, rd_data}, 20 + i);
    end
    check_model("steady_end");

    // Full with simultaneous read and write.
    for (int i = 0; i < 1024; i++) apply(1'b1, 1'b0, 8'(i + 7));
    check("prefull", {31'd0, wr_full}, 32'd1);
    apply(1'b1, 1'b1, 8'h55);
    check_model("full_both");
    check("full_both_rd", {24'd0, rd_data}, 32'h07);
    check("full_both_full", {31'd0, wr_full}, 32'd0);
    apply(1'b1, 1'b0, 8'h66);
    check("refill_full", {31'd0, wr_full}, 32'd1);

    // Reset pulse with 300 words stored.
    do_reset();
    for (int i = 0; i < 300; i++) apply(1'b1, 1'b0, 8'(i + 100));
    check_model("pre_rst300");
    do_reset();
    check_reset_state("rst300");
    apply(1'b1, 1'b0, 8'h11);
    check_model("fresh_wr");
    apply(1'b0, 1'b1, 8'h00);
    check("fresh_rd", {24'd0, rd_data}, 32'h11);
    check("fresh_empty", {31'd0, rd_empty}, 32'd1);
    check_model("fresh_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
